// File: rtl/pwm_tick_sched.sv
// pwm_tick_sched: tick prescaler and run sequencer for a free-running PWM
// period counter. It keeps a mirror of that counter so it knows which tick
// wraps the period, and it swaps divisors only on period boundaries so the
// tick spacing never glitches mid-period.
module pwm_tick_sched #(
    parameter int                   DIV_WIDTH = 16,
    parameter int                   CNT_WIDTH = 20,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_oneshot_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 abort_i,
    output logic                 tick_o,
    output logic                 period_o,
    output logic                 busy_o,
    output logic [DIV_WIDTH-1:0] div_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] presc;
    logic [CNT_WIDTH-1:0] mcnt;
    logic [DIV_WIDTH-1:0] act_div;
    logic                 oneshot;
    logic [DIV_WIDTH-1:0] pend_div;
    logic                 pend_vld;

    logic tick;
    logic wrap;
    logic xfer;
    logic run_end;

    // Outputs depend on registered state only, never directly on inputs.
    assign tick        = (state != IDLE) && (presc == act_div);
    assign wrap        = tick && (mcnt == '1);
    assign cfg_ready_o = (state == IDLE) || !pend_vld;
    assign xfer        = cfg_valid_i && cfg_ready_o;

    assign tick_o   = tick;
    assign period_o = wrap;
    assign busy_o   = (state != IDLE);
    assign div_o    = act_div;

    // Decide whether the current cycle is the last one of a run.
    always_comb begin
        run_end = 1'b0;
        case (state)
            RUN:     run_end = abort_i || (!stop_i && wrap && oneshot);
            DRAIN:   run_end = abort_i || wrap;
            default: run_end = 1'b0;
        endcase
    end

    // Sequencer: run state, prescaler, counter mirror and divisor commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            mcnt     <= '0;
            act_div  <= DIV_RESET;
            oneshot  <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc <= '0;
                    // A config written alongside start governs the new run.
                    if (xfer) begin
                        act_div <= cfg_div_i;
                        oneshot <= cfg_oneshot_i;
                    end
                    if (start_i && !stop_i && !abort_i) begin
                        state <= RUN;
                    end
                end

                RUN, DRAIN: begin
                    // The counter sees tick_o this cycle whatever else happens,
                    // so the mirror must follow it even on an abort.
                    if (tick) begin
                        presc <= '0;
                        mcnt  <= mcnt + CNT_WIDTH'(1);
                    end else begin
                        presc <= presc + DIV_WIDTH'(1);
                    end

                    if (run_end) begin
                        // Leaving the run: any outstanding divisor becomes active.
                        state    <= IDLE;
                        presc    <= '0;
                        pend_vld <= 1'b0;
                        if (xfer) begin
                            act_div <= cfg_div_i;
                        end else if (pend_vld) begin
                            act_div <= pend_div;
                        end
                    end else begin
                        if ((state == RUN) && stop_i) begin
                            state <= DRAIN;
                        end
                        // Commit a pending divisor only at the wrap; a value
                        // accepted on the wrap itself waits for the next one.
                        if (wrap && pend_vld) begin
                            act_div  <= pend_div;
                            pend_vld <= 1'b0;
                            presc    <= '0;
                        end else if (xfer) begin
                            pend_vld <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase
        end
    end

    // Pending divisor payload; qualified by pend_vld so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state != IDLE) && xfer) begin
            pend_div <= cfg_div_i;
        end
    end

endmodule

// File: doc/pwm_tick_sched.md
Name: pwm_tick_sched

Overview:
- Tick scheduler and sequencer for the free-running PWM period counter.
- Generates that counter's `tick_i` enable from the system clock through a programmable prescaler.
- Sequences runs (start, graceful stop, abort, one-shot) and mirrors the counter value so it knows exactly when a PWM period wraps.
- Accepts divisor updates through a valid/ready handshake and applies them glitch-free at period boundaries; sits between the register interface and the counter.

Parameters:
- DIV_WIDTH, 16, width of the prescaler divisor.
- CNT_WIDTH, 20, width of the driven period counter; must equal that counter's WIDTH.
- DIV_RESET, 0, active divisor value after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- cfg_valid_i  input  1  new configuration offered.
- cfg_ready_o  output  1  configuration can be accepted this cycle.
- cfg_div_i  input  DIV_WIDTH  divisor; tick period is cfg_div_i+1 clocks.
- cfg_oneshot_i  input  1  run mode for the next start: 1 = stop after one full period.
- start_i  input  1  start request (level-sampled, one-cycle effect).
- stop_i  input  1  graceful stop: finish the current period, then idle.
- abort_i  input  1  immediate stop.
- tick_o  output  1  one-cycle enable to the counter's tick_i.
- period_o  output  1  pulses with the tick that wraps the counter to 0.
- busy_o  output  1  state != IDLE.
- div_o  output  DIV_WIDTH  currently active divisor.

Behaviour:
- State encoding: FSM states IDLE, RUN, DRAIN.
- Registers:
  - presc: DIV_WIDTH-bit prescaler.
  - mcnt: CNT_WIDTH-bit mirror of the counter.
  - act_div, oneshot: active configuration.
  - pend_div, pend_vld: pending configuration.
- Reset values (async, rst high): state=IDLE, presc=0, mcnt=0, act_div=DIV_RESET, oneshot=0, pend_vld=0.
  - Outputs during/after reset: tick_o=0, period_o=0, busy_o=0, cfg_ready_o=1, div_o=DIV_RESET.
  - The counter's reset must be released together with rst so that mcnt stays equal to the counter; the system integrates it that way.
- tick_o and period_o are combinational from registered state only: no input-to-output path.
  - tick_o = (state!=IDLE) && (presc==act_div).
  - period_o = tick_o && (mcnt == all-ones).
- Prescaler and mirror: in RUN/DRAIN each clock,
  - presc == act_div: presc <= 0 and mcnt <= mcnt+1 (mod 2^CNT_WIDTH).
  - otherwise: presc <= presc+1.
  - presc is compared only by equality; no intermediate overflow.
- IDLE:
  - start_i=1 and stop_i=0 and abort_i=0 -> RUN with presc=0. The first tick_o comes act_div+1 cycles after the start_i cycle.
  - stop_i or abort_i has priority over start_i (remains IDLE).
- RUN:
  - abort_i -> IDLE, presc<=0.
  - Otherwise stop_i -> DRAIN.
  - Otherwise, on period_o with oneshot=1 -> IDLE.
  - start_i is ignored.
- DRAIN:
  - Keeps ticking; on period_o -> IDLE.
  - abort_i -> IDLE immediately.
  - stop_i and start_i are ignored.
- On any return to IDLE, presc is cleared and mcnt is preserved; the counter cannot be cleared.
- Config handshake, transfer when cfg_valid_i && cfg_ready_o:
  - IDLE: cfg_ready_o=1; act_div<=cfg_div_i and oneshot<=cfg_oneshot_i next cycle.
  - RUN/DRAIN: cfg_ready_o = !pend_vld. A transfer loads pend_div and sets pend_vld; cfg_oneshot_i is ignored while running.
  - A pending divisor is committed on the period_o cycle: act_div<=pend_div, pend_vld<=0, presc<=0.
  - A transfer in the same cycle as period_o is not committed at that wrap; it waits for the next one.
  - If the run ends with pend_vld=1 (abort, or a period_o that ends DRAIN/one-shot), the pending value is committed on entry to IDLE.
  - Transfers in the same cycle as an IDLE->RUN start write act_div first, so the new divisor governs the run.
- Simultaneous abort_i and cfg transfer in RUN: abort takes effect; the transferred value becomes active in IDLE.
- Edge case, DIV=0: tick_o is high every cycle in RUN/DRAIN.

Test Plan:
- Start with DIV_RESET=0, CNT_WIDTH=4, start_i pulse -> tick_o high every cycle; period_o on the 16th tick; busy_o=1 throughout.
- IDLE cfg div=3, oneshot=1, then start -> tick_o every 4 cycles, first tick 4 cycles after start; period_o on the 16th tick (cycle 64); busy_o drops the next cycle; no further ticks.
- RUN div=0, mid-period cfg div=2 (accepted; cfg_ready_o then 0; second offer stalls) -> ticks every cycle until period_o, then every 3 cycles; cfg_ready_o returns to 1; div_o=2.
- stop_i at mcnt=5 -> DRAIN continues 11 more ticks to the wrap, period_o, then IDLE; a start_i during DRAIN is ignored.
- abort_i at mcnt=5 -> next cycle busy_o=0, tick_o=0; a restart resumes at mcnt=5, with period_o after 11 ticks.
- Assert rst asynchronously mid-RUN between clock edges -> outputs reach reset values immediately; start_i and stop_i in the same IDLE cycle -> stays IDLE.
